// File: rtl/temporal_pkg.sv
// -----------------------------------------------------------------------------
// temporal_pkg
// Shared definitions for the temporal (unary) stream decoder:
//   state_t    - decoder FSM states
//   max_beats  - longest window a counter of a given width can absorb
// -----------------------------------------------------------------------------
package temporal_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // A window is closed at 2^width-1 beats, so no counter of that width can wrap.
  // Valid for widths up to 31.
  function automatic int unsigned max_beats(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/temporal_stream_decoder_if.sv
// -----------------------------------------------------------------------------
// temporal_stream_decoder_if
// Bundles the stream-in and result-out handshakes of the decoder.
//   start      - open a new decode window
//   in_valid   - in_bits/in_last carry a beat
//   in_bits    - one unary bit per lane, [row][col]
//   in_last    - final beat of the window (qualified by in_valid)
//   out_valid  - decoded matrix available
//   out_ready  - consumer accepts out
//   out        - per-lane 1-bit counts, [row][col]
//   timeout    - window closed by beat limit rather than in_last
//   busy       - decoder is accumulating or holding a result
// master: the producer/consumer side; slave: the decoder.
// -----------------------------------------------------------------------------
interface temporal_stream_decoder_if #(
  parameter int DIM       = 2,
  parameter int OUT_WIDTH = 8
);

  logic                                      start;
  logic                                      in_valid;
  logic [DIM-1:0][DIM-1:0]                   in_bits;
  logic                                      in_last;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0]    out;
  logic                                      timeout;
  logic                                      busy;

  modport master (
    output start, in_valid, in_bits, in_last, out_ready,
    input  out_valid, out, timeout, busy
  );

  modport slave (
    input  start, in_valid, in_bits, in_last, out_ready,
    output out_valid, out, timeout, busy
  );

endinterface

// File: rtl/temporal_lane_counter.sv
// -----------------------------------------------------------------------------
// temporal_lane_counter
// Counts the 1-bits seen on one lane of a temporal stream.
//   clk, reset_n - clock, synchronous active-low reset
//   clear        - zero the count (takes priority over enable)
//   enable       - a beat is being accepted this cycle
//   bit_in       - the lane's unary bit for this beat
//   count        - number of accepted beats with bit_in = 1
// -----------------------------------------------------------------------------
module temporal_lane_counter #(
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 bit_in,
  output logic [OUT_WIDTH-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && bit_in) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/temporal_stream_decoder.sv
// -----------------------------------------------------------------------------
// temporal_stream_decoder
// Converts a DIM x DIM temporal (unary) stream from an MXU back to binary
// lane counts. A window opens on start, accumulates in_valid beats, and closes
// on in_last or when the beat limit is reached. The result is held in a
// registered out bus until the consumer accepts it.
//   clk, reset_n - clock, synchronous active-low reset
//   bus (slave)  - stream input, result output and status (see interface)
// -----------------------------------------------------------------------------
module temporal_stream_decoder
  import temporal_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int DIM       = 2,
  parameter int OUT_WIDTH = 2 * BIT_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  temporal_stream_decoder_if.slave      bus
);

  localparam logic [OUT_WIDTH-1:0] MAX_BEATS = OUT_WIDTH'(max_beats(OUT_WIDTH));

  state_t                                 state_q;
  state_t                                 state_d;
  logic [OUT_WIDTH-1:0]                   beat_cnt_q;
  logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0] lane_cnt;
  logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0] lane_next;
  logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0] out_q;
  logic                                   timeout_q;
  logic                                   clear;
  logic                                   accept;
  logic                                   close;
  logic                                   limit_hit;

  // This beat brings the window to MAX_BEATS.
  assign limit_hit = (beat_cnt_q == MAX_BEATS - 1'b1);

  // ---------------------------------------------------------------------------
  // FSM next-state and control
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    accept  = 1'b0;
    close   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          clear   = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          if (bus.in_last || limit_hit) begin
            close   = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // The result is only released on the handshake; start chains the next
        // window into the same cycle so there is no idle bubble.
        if (bus.out_ready) begin
          if (bus.start) begin
            clear   = 1'b1;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Beat counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      beat_cnt_q <= '0;
    end else if (clear) begin
      beat_cnt_q <= '0;
    end else if (accept) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Lane counters; lane_next folds in the closing beat so it is included
  // in the captured result.
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      temporal_lane_counter #(
        .OUT_WIDTH (OUT_WIDTH)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .enable  (accept),
        .bit_in  (bus.in_bits[r][c]),
        .count   (lane_cnt[r][c])
      );

      assign lane_next[r][c] = lane_cnt[r][c] + OUT_WIDTH'(bus.in_bits[r][c]);
    end
  end

  // ---------------------------------------------------------------------------
  // Result register
  // ---------------------------------------------------------------------------
  // NOTE: the result register is reset even though it is only read while
  // out_valid is high, because out must read zero after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q     <= '0;
      timeout_q <= 1'b0;
    end else if (close) begin
      out_q     <= lane_next;
      // in_last wins when it coincides with the beat limit.
      timeout_q <= !bus.in_last;
    end
  end

  assign bus.out_valid = (state_q == HOLD);
  assign bus.out       = out_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_temporal_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_temporal_stream_decoder
// Self-checking bench for temporal_stream_decoder (DIM=2, OUT_WIDTH=8).
// Expected results are pushed to a queue when the closing beat is driven and
// popped when out_valid is observed.
// -----------------------------------------------------------------------------
module tb_temporal_stream_decoder;

  localparam int DIM = 2;
  localparam int OW  = 8;

  typedef logic [DIM-1:0][DIM-1:0][OW-1:0] mat_t;
  typedef logic [DIM-1:0][DIM-1:0]         bits_t;

  typedef struct packed {
    mat_t out;
    logic timeout;
  } res_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  res_t sb[$];

  temporal_stream_decoder_if #(.DIM(DIM), .OUT_WIDTH(OW)) bus ();

  temporal_stream_decoder #(
    .BIT_WIDTH (4),
    .DIM       (DIM),
    .OUT_WIDTH (OW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic mat_t all_lanes(input logic [OW-1:0] v);
    mat_t m;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        m[r][c] = v;
    return m;
  endfunction

  task automatic drive_beat(input bits_t b, input logic last);
    bus.in_valid = 1'b1;
    bus.in_bits  = b;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_bits  = '0;
    bus.in_last  = 1'b0;
  endtask

  task automatic open_window();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bits   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    checks++;
    if (bus.timeout !== 1'b0) begin
      failures++; $display("FAIL reset_timeout: got %b want 0", bus.timeout);
    end
    checks++;
    if (bus.out !== mat_t'('0)) begin
      failures++; $display("FAIL reset_out: got %h want 0", bus.out);
    end
  endtask

  // 10 beats: lane[0][0] high on beats 1..6, lane[1][1] on all, in_last on 10.
  // Start is driven in the very first cycle after reset release.
  task automatic test_basic();
    bits_t b;
    res_t  exp_r;
    res_t  got;
    reset_n   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL basic_start_after_reset: busy got %b want 1", bus.busy);
    end
    for (int k = 1; k <= 10; k++) begin
      b       = '0;
      b[0][0] = (k <= 6);
      b[1][1] = 1'b1;
      if (k == 10) begin
        exp_r         = '0;
        exp_r.out[0][0] = 8'd6;
        exp_r.out[1][1] = 8'd10;
        exp_r.timeout = 1'b0;
        sb.push_back(exp_r);
      end
      drive_beat(b, k == 10);
      if (k == 9) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          failures++; $display("FAIL basic_early_valid: got %b want 0", bus.out_valid);
        end
      end
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL basic_latency: out_valid got %b want 1", bus.out_valid);
    end
    exp_r = sb.pop_front();
    got   = {bus.out, bus.timeout};
    checks++;
    if (got !== exp_r) begin
      failures++; $display("FAIL basic_result: got %h want %h", got, exp_r);
    end
    release_result();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL basic_release: valid/busy got %b%b want 00",
                           bus.out_valid, bus.busy);
    end
  endtask

  // 255 beats all ones, no in_last: beat limit closes the window.
  task automatic test_timeout();
    res_t exp_r;
    res_t got;
    open_window();
    for (int k = 1; k <= 255; k++) begin
      if (k == 255) begin
        exp_r.out     = all_lanes(8'd255);
        exp_r.timeout = 1'b1;
        sb.push_back(exp_r);
      end
      drive_beat('1, 1'b0);
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL timeout_valid: got %b want 1", bus.out_valid);
    end
    exp_r = sb.pop_front();
    got   = {bus.out, bus.timeout};
    checks++;
    if (got !== exp_r) begin
      failures++; $display("FAIL timeout_result: got %h want %h", got, exp_r);
    end
    // Beat 256 arrives while holding and must be dropped.
    drive_beat('1, 1'b1);
    got = {bus.out, bus.timeout};
    checks++;
    if (got !== exp_r || bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL timeout_beat256: got %h valid %b want %h valid 1",
                           got, bus.out_valid, exp_r);
    end
    release_result();
  endtask

  // Result held with out_ready low while start/in_valid are pulsed.
  task automatic test_hold_stall();
    bits_t b1;
    bits_t b2;
    res_t  exp_r;
    res_t  got;
    bit    seen;
    b1 = '0; b1[0][0] = 1'b1; b1[1][0] = 1'b1;
    b2 = '0; b2[0][0] = 1'b1; b2[0][1] = 1'b1;
    open_window();
    drive_beat(b1, 1'b0);
    exp_r.out       = '0;
    exp_r.out[0][0] = 8'd2;
    exp_r.out[0][1] = 8'd1;
    exp_r.out[1][0] = 8'd1;
    exp_r.timeout   = 1'b0;
    sb.push_back(exp_r);
    drive_beat(b2, 1'b1);
    wait_valid(4, seen);
    checks++;
    if (seen !== 1'b1) begin
      failures++; $display("FAIL stall_wait: out_valid got 0 want 1");
    end
    exp_r = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      bus.start    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_bits  = '1;
      bus.in_last  = 1'b1;
      tick();
      got = {bus.out, bus.timeout};
      checks++;
      if (got !== exp_r || bus.out_valid !== 1'b1) begin
        failures++; $display("FAIL stall_hold[%0d]: got %h valid %b want %h valid 1",
                             k, got, bus.out_valid, exp_r);
      end
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bits  = '0;
    bus.in_last  = 1'b0;
    release_result();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL stall_to_idle: valid/busy got %b%b want 00",
                           bus.out_valid, bus.busy);
    end
  endtask

  // Accept and start in the same cycle chains straight into a new window.
  task automatic test_back_to_back();
    bits_t b;
    res_t  exp_r;
    res_t  got;
    bit    seen;
    b = '0; b[0][1] = 1'b1; b[1][1] = 1'b1;
    open_window();
    drive_beat(b, 1'b0);
    exp_r.out       = '0;
    exp_r.out[0][1] = 8'd2;
    exp_r.out[1][1] = 8'd2;
    exp_r.timeout   = 1'b0;
    sb.push_back(exp_r);
    drive_beat(b, 1'b1);
    wait_valid(4, seen);
    exp_r = sb.pop_front();
    got   = {bus.out, bus.timeout};
    checks++;
    if (seen !== 1'b1 || got !== exp_r) begin
      failures++; $display("FAIL b2b_first: seen %b got %h want %h", seen, got, exp_r);
    end
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_handover: busy/valid got %b%b want 10",
                           bus.busy, bus.out_valid);
    end
    drive_beat('1, 1'b0);
    drive_beat('1, 1'b0);
    exp_r.out     = all_lanes(8'd3);
    exp_r.timeout = 1'b0;
    sb.push_back(exp_r);
    drive_beat('1, 1'b1);
    wait_valid(4, seen);
    exp_r = sb.pop_front();
    got   = {bus.out, bus.timeout};
    checks++;
    if (seen !== 1'b1 || got !== exp_r) begin
      failures++; $display("FAIL b2b_second: seen %b got %h want %h", seen, got, exp_r);
    end
    release_result();
  endtask

  // Reset in mid-window discards the pending result.
  task automatic test_reset_mid();
    res_t exp_r;
    res_t got;
    bit   seen;
    open_window();
    repeat (4) drive_beat('1, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (bus.out !== mat_t'('0) || bus.timeout !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs: out %h timeout %b busy %b want 0 0 0",
                           bus.out, bus.timeout, bus.busy);
    end
    wait_valid(6, seen);
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL rstmid_no_valid: out_valid got 1 want 0");
    end
    open_window();
    drive_beat('1, 1'b0);
    exp_r.out     = all_lanes(8'd2);
    exp_r.timeout = 1'b0;
    sb.push_back(exp_r);
    drive_beat('1, 1'b1);
    wait_valid(4, seen);
    exp_r = sb.pop_front();
    got   = {bus.out, bus.timeout};
    checks++;
    if (seen !== 1'b1 || got !== exp_r) begin
      failures++; $display("FAIL rstmid_next: seen %b got %h want %h", seen, got, exp_r);
    end
    release_result();
  endtask

  // A beat presented with start is not counted.
  task automatic test_start_beat();
    res_t exp_r;
    res_t got;
    bit   seen;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_bits  = '1;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bits  = '0;
    exp_r.out     = all_lanes(8'd1);
    exp_r.timeout = 1'b0;
    sb.push_back(exp_r);
    drive_beat('1, 1'b1);
    wait_valid(4, seen);
    exp_r = sb.pop_front();
    got   = {bus.out, bus.timeout};
    checks++;
    if (seen !== 1'b1 || got !== exp_r) begin
      failures++; $display("FAIL start_beat: seen %b got %h want %h", seen, got, exp_r);
    end
    release_result();
  endtask

  // in_last on the first beat with all-zero bits yields an all-zero result.
  task automatic test_empty();
    res_t exp_r;
    res_t got;
    bit   seen;
    open_window();
    exp_r.out     = '0;
    exp_r.timeout = 1'b0;
    sb.push_back(exp_r);
    drive_beat('0, 1'b1);
    wait_valid(4, seen);
    exp_r = sb.pop_front();
    got   = {bus.out, bus.timeout};
    checks++;
    if (seen !== 1'b1 || got !== exp_r) begin
      failures++; $display("FAIL empty_window: seen %b got %h want %h", seen, got, exp_r);
    end
    release_result();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_timeout();
    test_hold_stall();
    test_back_to_back();
    test_reset_mid();
    test_start_beat();
    test_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/temporal_stream_decoder.md
TEMPORAL_STREAM_DECODER -- requirements
Module: temporal_stream_decoder

Interface
REQ-001 Parameter BIT_WIDTH, default 4: binary operand width of the producing temporal MXU.
REQ-002 Parameter DIM, default 2: output matrix is DIM x DIM lanes.
REQ-003 Parameter OUT_WIDTH, default 2*BIT_WIDTH: width of each decoded lane count.
REQ-004 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  open a new decode window.
REQ-007 in_valid  input  1  in_bits/in_last carry a beat this cycle.
REQ-008 in_bits  input  [DIM][DIM] x 1  one unary (temporal) bit per lane.
REQ-009 in_last  input  1  final beat of the window; qualified by in_valid.
REQ-010 out_valid  output  1  decoded matrix available.
REQ-011 out_ready  input  1  consumer accepts out.
REQ-012 out  output  [DIM][DIM][OUT_WIDTH]  per-lane count of 1-bits in the window.
REQ-013 timeout  output  1  window closed by beat limit, not by in_last; valid with out_valid.
REQ-014 busy  output  1  high in ACCUM or HOLD.

Function
REQ-015 FSM states SHALL be IDLE, ACCUM, HOLD.
REQ-016 IDLE: start=1 SHALL clear all lane counters and the beat counter, go to ACCUM; in_valid beats in IDLE (including the start cycle) SHALL be ignored.
REQ-017 ACCUM: each in_valid beat SHALL add in_bits[i][j] (0/1) to lane counter [i][j] and increment the beat counter; start SHALL be ignored.
REQ-018 MAX_BEATS = 2^OUT_WIDTH-1; counters therefore SHALL never wrap and no saturation logic is needed.
REQ-019 Window close: in ACCUM, in_valid&in_last, or the in_valid beat that makes beat count = MAX_BEATS, SHALL include that beat, copy all lane counts to the out register, go to HOLD.
REQ-020 timeout SHALL be 1 only when the close was caused by the beat limit without in_last; if both occur on the same beat, timeout SHALL be 0.
REQ-021 Latency: out_valid SHALL rise the cycle after the closing beat; out/timeout SHALL be registered and stable while out_valid=1.
REQ-022 HOLD: out_valid=1 until out_valid&out_ready; in_valid beats in HOLD SHALL be dropped.
REQ-023 HOLD with out_ready=1 and start=0 -> IDLE; with out_ready=1 and start=1 -> ACCUM with counters cleared (back-to-back windows, no bubble).
REQ-024 HOLD with out_ready=0: start SHALL be ignored; state and out unchanged.
REQ-025 Empty window (in_last on first beat with in_bits all 0) SHALL yield out all zero, out_valid normally.
REQ-026 Lane order SHALL match the MXU output: out[row][col] decodes in_bits[row][col].

Reset
REQ-027 reset_n=0 at posedge clk SHALL force IDLE, out_valid=0, timeout=0, busy=0, out=0, all counters 0, regardless of state.
REQ-028 Reset asserted mid-window or in HOLD SHALL discard the pending result with no out_valid pulse.
REQ-029 First start SHALL be honoured the first cycle after reset_n returns high.

Structure
REQ-030 Shared package temporal_pkg SHALL hold the state enum (IDLE/ACCUM/HOLD) and the MAX_BEATS derivation function.
REQ-031 One sub-module temporal_lane_counter (clear, enable, bit in, OUT_WIDTH count out) SHALL be instantiated DIM*DIM times via generate.
REQ-032 The FSM, beat counter and out register SHALL live in temporal_stream_decoder.

Verification
REQ-033 start; 10 beats, lane[0][0] ones on 6 beats, lane[1][1] on 10, others 0, in_last on beat 10 -> out[0][0]=6, [1][1]=10, others 0, timeout=0, out_valid one cycle after beat 10.
REQ-034 start; 255 beats all ones, no in_last -> all lanes 255, timeout=1; beat 256 dropped.
REQ-035 out_ready low 5 cycles, start and in_valid pulsed during HOLD -> out stable, no new window; out_ready high -> IDLE.
REQ-036 out_ready=1 and start=1 same HOLD cycle, then 3 beats of ones with in_last -> second result all lanes 3, no idle cycle between windows.
REQ-037 reset_n low for one cycle after 4 beats of a window -> out_valid never asserted; outputs 0; new start then 2 beats ones -> all lanes 2.
REQ-038 start with in_valid=1 same cycle, then 1 beat in_last with in_bits all 1 -> all lanes 1 (start-cycle beat not counted).
